// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with occupancy count.
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   push, din     enqueue request and data (ignored while full)
//   pop, dout     dequeue request (ignored while empty); dout shows the head entry
//   count         entries currently stored (0..DEPTH)
//   full, empty   count == DEPTH / count == 0
// Storage is not cleared by reset; only pointers and count are.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CountFull = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CountFull);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];

  // Both qualifiers use the pre-edge count: a push while full is dropped even
  // if a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CountOne;
        2'b01:   count_q <= count_q - CountOne;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through its strobe/busy handshake.
// Ports:
//   i_clk, i_rst        clock and synchronous active-high reset
//   wr_data, wr_strobe  CPU-side enqueue
//   full, empty, count  FIFO occupancy
//   overflow            sticky: a write was dropped while full (cleared by reset only)
//   idle                FIFO empty, drain FSM idle and transmitter not busy
//   tx_data, tx_strobe  registered byte and one-cycle send request to the transmitter
//   tx_busy             transmitter busy flag
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_strobe,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              idle,
  output logic [7:0]        tx_data,
  output logic              tx_strobe,
  input  logic              tx_busy
);

  typedef enum logic [1:0] {
    StIdle,
    StWaitAck,
    StWaitDone
  } state_e;

  state_e     state_q, state_d;
  logic       tx_strobe_q, tx_strobe_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       overflow_q;
  logic       pop;
  logic [7:0] head;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (wr_strobe),
    .pop   (pop),
    .din   (wr_data),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Drain FSM. The strobe is only launched from StIdle with tx_busy sampled low,
  // and StWaitAck drops it on the next edge, so it is never wider than one cycle.
  always_comb begin
    state_d     = state_q;
    tx_strobe_d = 1'b0;
    tx_data_d   = tx_data_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !tx_busy) begin
          pop         = 1'b1;
          tx_strobe_d = 1'b1;
          tx_data_d   = head;
          state_d     = StWaitAck;
        end
      end
      StWaitAck: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      tx_strobe_q <= 1'b0;
      tx_data_q   <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_strobe_q <= tx_strobe_d;
      tx_data_q   <= tx_data_d;
      if (wr_strobe && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign tx_strobe = tx_strobe_q;
  assign tx_data   = tx_data_q;
  assign overflow  = overflow_q;
  assign idle      = empty && (state_q == StIdle) && !tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter (frame of 40 busy cycles,
// i.e. 10 bits at 4 clocks per bit). Received bytes are logged at strobe acceptance.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_strobe = 1'b0;
  logic       full, empty, overflow, idle, tx_strobe;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_busy;

  logic       hold_busy = 1'b0;
  logic       model_busy = 1'b0;
  int         frame_cnt = 0;
  logic [7:0] rx_mem [256];
  int         rx_n = 0;
  int         viol = 0;
  logic       strobe_prev = 1'b0;
  int         peak = 0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign tx_busy = hold_busy | model_busy;

  uart_tx_fifo #(
    .DEPTH (16)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .wr_data   (wr_data),
    .wr_strobe (wr_strobe),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .idle      (idle),
    .tx_data   (tx_data),
    .tx_strobe (tx_strobe),
    .tx_busy   (tx_busy)
  );

  // Transmitter model: no reset, accepts a strobe only while not busy.
  always @(posedge clk) begin
    strobe_prev <= tx_strobe;
    if ((tx_strobe && tx_busy) || (tx_strobe && strobe_prev)) viol <= viol + 1;
    if (model_busy) begin
      if (frame_cnt == 1) model_busy <= 1'b0;
      frame_cnt <= frame_cnt - 1;
    end else if (tx_strobe && !tx_busy) begin
      model_busy   <= 1'b1;
      frame_cnt    <= 40;
      rx_mem[rx_n] <= tx_data;
      rx_n         <= rx_n + 1;
    end
  end

  always @(negedge clk) begin
    if (int'(count) > peak) peak <= int'(count);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic write_burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_data   = first + 8'(i);
      wr_strobe = 1'b1;
    end
    @(negedge clk) wr_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (idle) break;
    end
    check(tag, 32'(idle), 32'd1);
  endtask

  initial begin
    int base;
    do_reset();
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_strobe", 32'(tx_strobe), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_idle", 32'(idle), 1);

    // Single byte: strobe the edge after the write, busy the edge after that.
    base = rx_n;
    @(negedge clk) wr_data = 8'hA5; wr_strobe = 1'b1;
    @(negedge clk) wr_strobe = 1'b0;
    check("e0_count", 32'(count), 1);
    check("e0_strobe", 32'(tx_strobe), 0);
    @(negedge clk);
    check("e1_strobe", 32'(tx_strobe), 1);
    check("e1_data", 32'(tx_data), 32'hA5);
    check("e1_count", 32'(count), 0);
    @(negedge clk);
    check("e2_strobe", 32'(tx_strobe), 0);
    check("e2_busy", 32'(tx_busy), 1);
    wait_idle("single_idle", 200);
    check("single_n", 32'(rx_n - base), 1);
    check("single_byte", 32'(rx_mem[base]), 32'hA5);

    // Burst of five.
    base = rx_n;
    @(negedge clk) peak = 0;
    write_burst(8'h01, 5);
    wait_idle("burst_idle", 1000);
    check("burst_peak", 32'(peak), 4);
    check("burst_n", 32'(rx_n - base), 5);
    for (int i = 0; i < 5; i++) check("burst_byte", 32'(rx_mem[base + i]), 32'(i + 1));

    // Overflow with transmitter held busy.
    base = rx_n;
    @(negedge clk) hold_busy = 1'b1;
    write_burst(8'h10, 18);
    check("ovf_count", 32'(count), 16);
    check("ovf_full", 32'(full), 1);
    check("ovf_flag", 32'(overflow), 1);
    @(negedge clk) hold_busy = 1'b0;
    wait_idle("ovf_idle", 1500);
    check("ovf_n", 32'(rx_n - base), 16);
    for (int i = 0; i < 16; i++) check("ovf_byte", 32'(rx_mem[base + i]), 32'(8'h10 + i));
    check("ovf_count0", 32'(count), 0);
    check("ovf_empty", 32'(empty), 1);

    // Write while full on the same edge as a pop.
    do_reset();
    check("rst2_ovf", 32'(overflow), 0);
    base = rx_n;
    @(negedge clk) hold_busy = 1'b1;
    write_burst(8'h40, 16);
    check("fp_full", 32'(full), 1);
    @(negedge clk) hold_busy = 1'b0; wr_data = 8'hEE; wr_strobe = 1'b1;
    @(negedge clk) wr_strobe = 1'b0;
    check("fp_count", 32'(count), 15);
    check("fp_ovf", 32'(overflow), 1);
    check("fp_strobe", 32'(tx_strobe), 1);
    wait_idle("fp_idle", 1500);
    check("fp_n", 32'(rx_n - base), 16);
    check("fp_last", 32'(rx_mem[base + 15]), 32'h4F);

    // Reset mid-frame with three bytes queued.
    do_reset();
    base = rx_n;
    write_burst(8'h30, 4);
    repeat (10) @(negedge clk);
    check("mid_count", 32'(count), 3);
    check("mid_busy", 32'(tx_busy), 1);
    do_reset();
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_strobe", 32'(tx_strobe), 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!tx_busy) break;
    end
    check("mid_busy_fall", 32'(tx_busy), 0);
    repeat (3) @(negedge clk);
    check("mid_no_send", 32'(rx_n - base), 1);
    write_burst(8'h5A, 1);
    wait_idle("mid_idle", 200);
    check("mid_n", 32'(rx_n - base), 2);
    check("mid_first", 32'(rx_mem[base]), 32'h30);
    check("mid_new", 32'(rx_mem[base + 1]), 32'h5A);

    // Pointer wrap: 40 bytes paced by !full.
    do_reset();
    base = rx_n;
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 5000 && sent < 40; c++) begin
        @(negedge clk);
        if (!full) begin
          wr_data   = 8'((sent * 7) % 256);
          wr_strobe = 1'b1;
          sent++;
        end else begin
          wr_strobe = 1'b0;
        end
      end
      @(negedge clk) wr_strobe = 1'b0;
      check("wrap_sent", 32'(sent), 40);
    end
    wait_idle("wrap_idle", 3000);
    check("wrap_n", 32'(rx_n - base), 40);
    for (int i = 0; i < 40; i++) check("wrap_byte", 32'(rx_mem[base + i]), 32'((i * 7) % 256));
    check("wrap_ovf", 32'(overflow), 0);

    check("handshake_viol", 32'(viol), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
